handshaked_reg_pipe: RTL and testbench

- Parametrised successor to the single-bit D register.
- A chain of DEPTH registered stages carrying a DATA_WIDTH-bit word, each with valid/ready handshake and backpressure.
- Full throughput: one word per cycle.
- Used to cut long timing paths between handshaked producers and consumers, e.g. stream interconnect and memory-request paths.

---
 rtl/handshaked_reg_pkg.sv | 23 ++
 rtl/handshaked_reg_pipe_if.sv | 11 +
 rtl/handshaked_reg_stage.sv | 38 +++
 rtl/handshaked_reg_pipe.sv | 96 +++++++++
 tb/tb_handshaked_reg_pipe.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/handshaked_reg_pkg.sv
// rtl/handshaked_reg_pkg.sv - shared constants, stage record type and width helpers for the handshaked register pipe
package handshaked_reg_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 2;

    typedef struct packed {
        logic                          vld;
        logic [DEFAULT_DATA_WIDTH-1:0] data;
    } stage_rec_t;

    function automatic int clog2(input int value);
        int w = 0;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    // A zero-depth pipe still exposes a 1-bit (constant zero) occupancy port.
    function automatic int occ_width(input int depth);
        return (depth > 0) ? clog2(depth + 1) : 1;
    endfunction

endpackage

// File: rtl/handshaked_reg_pipe_if.sv
// rtl/handshaked_reg_pipe_if.sv - valid/ready word channel used on both sides of the register pipe
interface handshaked_reg_pipe_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  vld;
    logic                  rd;

    modport master (output data, output vld, input rd);
    modport slave  (input data, input vld, output rd);
endinterface

// File: rtl/handshaked_reg_stage.sv
// rtl/handshaked_reg_stage.sv - one registered valid/ready stage of the pipe
module handshaked_reg_stage
    import handshaked_reg_pkg::*;
#(
    parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_src_vld,
    input  logic [DATA_WIDTH-1:0] i_src_data,
    input  logic                  i_next_rd,
    output logic                  o_rd,
    output logic                  o_vld,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  r_vld;
    logic [DATA_WIDTH-1:0] r_data;

    // Ready depends only on our own valid and downstream ready, never on i_src_vld.
    assign o_rd   = !r_vld || i_next_rd;
    assign o_vld  = r_vld;
    assign o_data = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_data <= INIT_VALUE;
        end else if (o_rd) begin
            r_vld <= i_src_vld;
            if (i_src_vld) begin
                r_data <= i_src_data;
            end
        end
    end

endmodule

// File: rtl/handshaked_reg_pipe.sv
// rtl/handshaked_reg_pipe.sv - DEPTH-stage valid/ready register pipe; occupancy port with HANDSHAKED_REG_PIPE_OCCUPANCY_EN
module handshaked_reg_pipe
    import handshaked_reg_pkg::*;
#(
    parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int                    DEPTH      = DEFAULT_DEPTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    handshaked_reg_pipe_if.slave         dataIn,
    handshaked_reg_pipe_if.master        dataOut
`ifdef HANDSHAKED_REG_PIPE_OCCUPANCY_EN
    ,
    output logic [occ_width(DEPTH)-1:0]  occupancy
`endif
);

    localparam int OW = occ_width(DEPTH);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk ^ rst;
            assign dataOut.data     = dataIn.data;
            assign dataOut.vld      = dataIn.vld;
            assign dataIn.rd        = dataOut.rd;
`ifdef HANDSHAKED_REG_PIPE_OCCUPANCY_EN
            assign occupancy        = '0;
`endif
        end else begin : g_pipe
            // Per-stage nets keep the ready chain split so it never looks like a self-loop.
            for (genvar i = 0; i < DEPTH; i++) begin : g_stage
                logic                  w_src_vld;
                logic [DATA_WIDTH-1:0] w_src_data;
                logic                  w_next_rd;
                logic                  w_rd;
                logic                  w_vld;
                logic [DATA_WIDTH-1:0] w_data;

                if (i == 0) begin : g_first
                    assign w_src_vld  = dataIn.vld;
                    assign w_src_data = dataIn.data;
                end else begin : g_mid
                    assign w_src_vld  = g_stage[i-1].w_vld;
                    assign w_src_data = g_stage[i-1].w_data;
                end

                if (i == DEPTH - 1) begin : g_last
                    assign w_next_rd = dataOut.rd;
                end else begin : g_inner
                    assign w_next_rd = g_stage[i+1].w_rd;
                end

                handshaked_reg_stage #(
                    .DATA_WIDTH (DATA_WIDTH),
                    .INIT_VALUE (INIT_VALUE)
                ) u_stage (
                    .clk        (clk),
                    .rst        (rst),
                    .i_src_vld  (w_src_vld),
                    .i_src_data (w_src_data),
                    .i_next_rd  (w_next_rd),
                    .o_rd       (w_rd),
                    .o_vld      (w_vld),
                    .o_data     (w_data)
                );
            end

            assign dataIn.rd    = g_stage[0].w_rd;
            assign dataOut.vld  = g_stage[DEPTH-1].w_vld;
            assign dataOut.data = g_stage[DEPTH-1].w_data;

`ifdef HANDSHAKED_REG_PIPE_OCCUPANCY_EN
            logic          w_in_xfer;
            logic          w_out_xfer;
            logic [OW-1:0] r_occupancy;

            assign w_in_xfer  = dataIn.vld && dataIn.rd;
            assign w_out_xfer = dataOut.vld && dataOut.rd;
            assign occupancy  = r_occupancy;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_occupancy <= '0;
                end else if (w_in_xfer && !w_out_xfer) begin
                    r_occupancy <= r_occupancy + OW'(1);
                end else if (!w_in_xfer && w_out_xfer) begin
                    r_occupancy <= r_occupancy - OW'(1);
                end
            end
`endif
        end
    endgenerate

endmodule

// File: tb/tb_handshaked_reg_pipe.sv
// tb/tb_handshaked_reg_pipe.sv - self-checking bench for handshaked_reg_pipe at DEPTH 2, 3 and 0
module tb_handshaked_reg_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    handshaked_reg_pipe_if #(.DATA_WIDTH(8)) in2 ();
    handshaked_reg_pipe_if #(.DATA_WIDTH(8)) out2 ();
    handshaked_reg_pipe_if #(.DATA_WIDTH(8)) in3 ();
    handshaked_reg_pipe_if #(.DATA_WIDTH(8)) out3 ();
    handshaked_reg_pipe_if #(.DATA_WIDTH(8)) in0 ();
    handshaked_reg_pipe_if #(.DATA_WIDTH(8)) out0 ();

`ifdef HANDSHAKED_REG_PIPE_OCCUPANCY_EN
    logic [1:0] occ2;
    logic [1:0] occ3;
    logic [0:0] occ0;
`endif

    handshaked_reg_pipe #(.DATA_WIDTH(8), .DEPTH(2), .INIT_VALUE(8'h5A)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .dataIn    (in2),
        .dataOut   (out2)
`ifdef HANDSHAKED_REG_PIPE_OCCUPANCY_EN
        ,
        .occupancy (occ2)
`endif
    );

    handshaked_reg_pipe #(.DATA_WIDTH(8), .DEPTH(3), .INIT_VALUE(8'h00)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .dataIn    (in3),
        .dataOut   (out3)
`ifdef HANDSHAKED_REG_PIPE_OCCUPANCY_EN
        ,
        .occupancy (occ3)
`endif
    );

    handshaked_reg_pipe #(.DATA_WIDTH(8), .DEPTH(0), .INIT_VALUE(8'h00)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .dataIn    (in0),
        .dataOut   (out0)
`ifdef HANDSHAKED_REG_PIPE_OCCUPANCY_EN
        ,
        .occupancy (occ0)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference for the DEPTH=3 pipe: slot[i] holds a word (or -1 for empty).
    // Each cycle the highest bubble (or the output, when it is taken) lets every slot below it move up one place.
    int slot [3];
    int sb[$];
    bit m_live  = 0;
    int dut_del = 0;

    always @(negedge clk) begin
        bit exp_in_rd;
        bit exp_out_vld;
        int k;
        int pop;
        int front;
        exp_in_rd   = (slot[0] < 0) || (slot[1] < 0) || (slot[2] < 0) || (out3.rd === 1'b1);
        exp_out_vld = slot[2] >= 0;
        if (m_live) begin
            chk("u3 in_rd", {31'b0, in3.rd}, {31'b0, exp_in_rd});
            chk("u3 out_vld", {31'b0, out3.vld}, {31'b0, exp_out_vld});
            if (exp_out_vld) chk("u3 out_data", {24'b0, out3.data}, slot[2]);
`ifdef HANDSHAKED_REG_PIPE_OCCUPANCY_EN
            pop = 0;
            for (int i = 0; i < 3; i++) if (slot[i] >= 0) pop++;
            chk("u3 occupancy", {30'b0, occ3}, pop);
            chk("u3 occupancy vs scoreboard", {30'b0, occ3}, sb.size());
`endif
        end
        if (rst) begin
            for (int i = 0; i < 3; i++) slot[i] = -1;
            sb.delete();
            m_live = 1;
        end else if (m_live) begin
            if (out3.vld === 1'b1 && out3.rd === 1'b1) begin
                dut_del++;
                if (sb.size() == 0) chk("u3 spurious output", 1, 0);
                else begin
                    front = sb.pop_front();
                    chk("u3 order", {24'b0, out3.data}, front);
                end
            end
            k = -1;
            if (out3.rd === 1'b1) k = 3;
            else for (int i = 0; i < 3; i++) if (slot[i] < 0) k = i;
            if (k >= 0) begin
                for (int i = 2; i >= 1; i--) if (i <= k) slot[i] = slot[i-1];
                slot[0] = (in3.vld === 1'b1) ? int'(in3.data) : -1;
                if (in3.vld === 1'b1) sb.push_back(int'(in3.data));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int cyc;
        int del_snap;
        logic [7:0] d;
        in2.vld = 0; in2.data = 0; out2.rd = 0;
        in3.vld = 0; in3.data = 0; out3.rd = 0;
        in0.vld = 0; in0.data = 0; out0.rd = 0;

        // Reset: two cycles high
        rst = 1;
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rst out_vld", {31'b0, out2.vld}, 0);
        chk("rst out_data", {24'b0, out2.data}, 32'h5A);
        chk("rst in_rd", {31'b0, in2.rd}, 1);
`ifdef HANDSHAKED_REG_PIPE_OCCUPANCY_EN
        chk("rst occupancy", {30'b0, occ2}, 0);
`endif
        next_cycle();

        // Streaming 0x01..0x10, no backpressure
        out2.rd = 1;
        for (int c = 0; c < 19; c++) begin
            if (c < 16) begin in2.vld = 1; in2.data = 8'(c + 1); end
            else in2.vld = 0;
            @(negedge clk);
            if (c < 16) chk("stream in_rd", {31'b0, in2.rd}, 1);
            chk("stream out_vld", {31'b0, out2.vld}, (c >= 2 && c < 18) ? 1 : 0);
            if (c >= 2 && c < 18) chk("stream out_data", {24'b0, out2.data}, c - 1);
            next_cycle();
        end

        // Backpressure: A1, A2 fill the pipe, A3 waits
        out2.rd = 0;
        in2.vld = 1; in2.data = 8'hA1;
        @(negedge clk); chk("bp in_rd A1", {31'b0, in2.rd}, 1);
        next_cycle();
        in2.data = 8'hA2;
        @(negedge clk); chk("bp in_rd A2", {31'b0, in2.rd}, 1);
        next_cycle();
        in2.data = 8'hA3;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            chk("bp in_rd full", {31'b0, in2.rd}, 0);
            chk("bp out_vld stalled", {31'b0, out2.vld}, 1);
            chk("bp out_data stable", {24'b0, out2.data}, 32'hA1);
`ifdef HANDSHAKED_REG_PIPE_OCCUPANCY_EN
            chk("bp occupancy", {30'b0, occ2}, 2);
`endif
            next_cycle();
        end
        out2.rd = 1;
        #1;
        chk("bp in_rd on release", {31'b0, in2.rd}, 1);
        @(negedge clk);
        chk("bp out A1", {24'b0, out2.data}, 32'hA1);
        next_cycle();
        in2.vld = 0;
        @(negedge clk);
        chk("bp out_vld A2", {31'b0, out2.vld}, 1);
        chk("bp out A2", {24'b0, out2.data}, 32'hA2);
        next_cycle();
        @(negedge clk);
        chk("bp out_vld A3", {31'b0, out2.vld}, 1);
        chk("bp out A3", {24'b0, out2.data}, 32'hA3);
        next_cycle();
        @(negedge clk);
        chk("bp drained", {31'b0, out2.vld}, 0);
        next_cycle();

        // DEPTH=0 passthrough
        in0.data = 8'h3C; in0.vld = 1; out0.rd = 0;
        #1;
        chk("d0 out_data", {24'b0, out0.data}, 32'h3C);
        chk("d0 out_vld", {31'b0, out0.vld}, 1);
        chk("d0 in_rd", {31'b0, in0.rd}, 0);
`ifdef HANDSHAKED_REG_PIPE_OCCUPANCY_EN
        chk("d0 occupancy", {31'b0, occ0}, 0);
`endif
        for (int t = 0; t < 8; t++) begin
            d = 8'($urandom);
            in0.data = d; in0.vld = 1'($urandom); out0.rd = 1'($urandom);
            #1;
            chk("d0 rand data", {24'b0, out0.data}, {24'b0, d});
            chk("d0 rand vld", {31'b0, out0.vld}, {31'b0, in0.vld});
            chk("d0 rand rd", {31'b0, in0.rd}, {31'b0, out0.rd});
        end
        next_cycle();

        // Random traffic into DEPTH=3: 1000 words
        acc = 0; cyc = 0;
        while (acc < 1000 && cyc < 20000) begin
            in3.vld = ($urandom_range(0, 3) != 0);
            in3.data = 8'($urandom);
            out3.rd = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (in3.vld && in3.rd) acc++;
            next_cycle();
            cyc++;
        end
        chk("random words accepted", acc, 1000);
        in3.vld = 0; out3.rd = 1;
        for (int t = 0; t < 5; t++) next_cycle();
        chk("random words delivered", dut_del, 1000);

        // Mid-operation reset with two words in flight
        out3.rd = 0;
        in3.vld = 1; in3.data = 8'hE1; next_cycle();
        in3.data = 8'hE2; next_cycle();
        in3.data = 8'hE3; rst = 1; next_cycle();
        rst = 0; in3.vld = 0;
        @(negedge clk);
        chk("midrst out_vld", {31'b0, out3.vld}, 0);
        chk("midrst in_rd", {31'b0, in3.rd}, 1);
`ifdef HANDSHAKED_REG_PIPE_OCCUPANCY_EN
        chk("midrst occupancy", {30'b0, occ3}, 0);
`endif
        next_cycle();
        del_snap = dut_del;
        out3.rd = 1;
        for (int t = 0; t < 6; t++) next_cycle();
        chk("midrst nothing delivered", dut_del, del_snap);

        // Short random run after reset
        for (int t = 0; t < 200; t++) begin
            in3.vld = 1'($urandom); in3.data = 8'($urandom); out3.rd = 1'($urandom);
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
